sdm_mash_n: RTL and testbench

SDM_MASH_N -- requirements
Module: sdm_mash_n

---
 rtl/sdm_pkg.sv | 15 +
 rtl/sdm_acc_stage.sv | 35 +++
 rtl/sdm_mash_n.sv | 124 ++++++++++++
 tb/tb_sdm_mash_n.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
// Shared constants for the MASH sigma-delta modulator: stage limit, dither LFSR
// definition and the output width helper.
package sdm_pkg;

    localparam int          SDM_MAX_STG = 4;
    localparam int          LFSR_W      = 15;
    localparam logic [14:0] LFSR_SEED   = 15'h0001;
    // Feedback taps for x^15 + x^14 + 1 (bits 14 and 13 of the shift register).
    localparam logic [14:0] LFSR_TAPS   = 15'h6000;

    function automatic int sdm_out_w(input int nstg);
        return nstg + 1;
    endfunction

endpackage

// File: rtl/sdm_acc_stage.sv
// One first-order MASH stage: W-bit phase accumulator whose overflow is the
// stage carry. hold_zero keeps an inactive stage parked at zero.
module sdm_acc_stage
    import sdm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         clr,
    input  logic         hold_zero,
    input  logic [W-1:0] addend,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W-1:0] acc;
    logic [W:0]   full;

    assign full  = {1'b0, acc} + {1'b0, addend};
    assign sum   = full[W-1:0];
    assign carry = hold_zero ? 1'b0 : full[W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= hold_zero ? '0 : full[W-1:0];
        end
    end

endmodule

// File: rtl/sdm_mash_n.sv
// MASH 1-1-..-1 sigma-delta modulator with run-time order selection, optional
// LFSR dither on stage 1, and registered noise-cancelled output.
module sdm_mash_n
    import sdm_pkg::*;
#(
    parameter int W      = 16,
    parameter int NSTG   = 3,
    parameter int DITHER = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   clr,
    input  logic [1:0]             order,
    input  logic [W-1:0]           din,
    output logic signed [NSTG:0]   dout,
    output logic                   dout_vld,
    output logic [NSTG-1:0]        carry
);

    localparam int         OW      = sdm_out_w(NSTG);
    localparam logic [1:0] MAX_ORD = 2'(NSTG - 1);

    // Sample handshake: each cycle with en=1 (and clr=0) consumes din and
    // produces one dout, flagged by a one-cycle dout_vld pulse on the next cycle.
    logic [1:0]          ord_eff;
    logic [NSTG-1:0]     active;
    logic [LFSR_W-1:0]   lfsr;
    logic                dith;
    logic [W-1:0]        stg_in  [NSTG];
    logic [W-1:0]        stg_sum [NSTG];
    logic [NSTG-1:0]     c;
    logic signed [OW-1:0] dreg [NSTG][NSTG];
    logic signed [OW-1:0] dnxt [NSTG][NSTG];
    logic signed [OW-1:0] y;
    logic signed [OW-1:0] d;

    assign ord_eff   = (order > MAX_ORD) ? MAX_ORD : order;
    assign dith      = (DITHER != 0) ? lfsr[0] : 1'b0;
    assign stg_in[0] = din + W'(dith);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= LFSR_SEED;
        end else if (clr) begin
            lfsr <= LFSR_SEED;
        end else if (en) begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        assign active[k] = (ord_eff >= 2'(k));
        if (k > 0) begin : g_chain
            assign stg_in[k] = stg_sum[k-1];
        end
        sdm_acc_stage #(.W(W)) u_stage (
            .clk       (clk),
            .rstn      (rstn),
            .en        (en),
            .clr       (clr),
            .hold_zero (!active[k]),
            .addend    (stg_in[k]),
            .sum       (stg_sum[k]),
            .carry     (c[k])
        );
    end

    // Stage k gets k cascaded first differences; dreg[k][j] holds the previous
    // input of difference j. Masking by active makes a stage drop out instantly.
    always_comb begin
        y = '0;
        d = '0;
        for (int k = 0; k < NSTG; k++) begin
            for (int j = 0; j < NSTG; j++) begin
                dnxt[k][j] = '0;
            end
        end
        for (int k = 0; k < NSTG; k++) begin
            d = {{(OW-1){1'b0}}, c[k]};
            for (int j = 0; j < NSTG; j++) begin
                if (j < k) begin
                    dnxt[k][j] = active[k] ? d : '0;
                    d = d - (active[k] ? dreg[k][j] : '0);
                end
            end
            y = y + d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            carry    <= '0;
            for (int k = 0; k < NSTG; k++) begin
                for (int j = 0; j < NSTG; j++) begin
                    dreg[k][j] <= '0;
                end
            end
        end else if (clr) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            carry    <= '0;
            for (int k = 0; k < NSTG; k++) begin
                for (int j = 0; j < NSTG; j++) begin
                    dreg[k][j] <= '0;
                end
            end
        end else begin
            dout_vld <= en;
            if (en) begin
                dout  <= y;
                carry <= c;
                for (int k = 0; k < NSTG; k++) begin
                    for (int j = 0; j < NSTG; j++) begin
                        dreg[k][j] <= dnxt[k][j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sdm_mash_n.sv
// Directed bench for sdm_mash_n (W=8, NSTG=3, no dither) with a closed-form
// MASH 1-1-1 reference model built from per-stage carry history.
module tb_sdm_mash_n;

    logic              clk;
    logic              rstn;
    logic              en;
    logic              clr;
    logic [1:0]        order;
    logic [7:0]        din;
    logic signed [3:0] dout;
    logic              dout_vld;
    logic [2:0]        carry;

    int n_cmp;
    int n_err;

    // reference model state
    logic [7:0] macc [3];
    logic       mc   [3];
    int         h1p, h2p, h2pp;
    int         my;
    logic       exp_vld;

    sdm_mash_n #(.W(8), .NSTG(3), .DITHER(0)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .clr      (clr),
        .order    (order),
        .din      (din),
        .dout     (dout),
        .dout_vld (dout_vld),
        .carry    (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clr();
        for (int k = 0; k < 3; k++) begin
            macc[k] = 8'd0;
            mc[k]   = 1'b0;
        end
        h1p = 0; h2p = 0; h2pp = 0; my = 0;
    endtask

    task automatic model_step(input logic [1:0] ord, input logic [7:0] d);
        int         o;
        logic [8:0] s;
        logic [7:0] x;
        int         c0, c1, c2;
        o = (ord > 2'd2) ? 2 : int'(ord);
        x = d;
        for (int k = 0; k < 3; k++) begin
            if (k <= o) begin
                s       = {1'b0, macc[k]} + {1'b0, x};
                mc[k]   = s[8];
                macc[k] = s[7:0];
                x       = s[7:0];
            end else begin
                mc[k]   = 1'b0;
                macc[k] = 8'd0;
            end
        end
        if (o < 1) h1p = 0;
        if (o < 2) begin
            h2p  = 0;
            h2pp = 0;
        end
        c0 = int'(mc[0]);
        c1 = int'(mc[1]);
        c2 = int'(mc[2]);
        my = c0 + (c1 - h1p) + (c2 - 2 * h2p + h2pp);
        h2pp = h2p;
        h2p  = c2;
        h1p  = c1;
    endtask

    // drive one clock with the given en/clr, then advance the model to match
    task automatic cycle(input logic en_v, input logic clr_v);
        en  = en_v;
        clr = clr_v;
        @(posedge clk);
        #1;
        en  = 1'b0;
        clr = 1'b0;
        if (clr_v) model_clr();
        else if (en_v) model_step(order, din);
        exp_vld = en_v && !clr_v;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; clr = 1'b0; order = 2'd0; din = 8'd0;
        model_clr();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (dout !== 4'sd0) begin n_err++; $display("FAIL reset_dout got=%0d exp=0", dout); end
        n_cmp++;
        if (dout_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got=%b exp=0", dout_vld); end
        n_cmp++;
        if (carry !== 3'b000) begin n_err++; $display("FAIL reset_carry got=%b exp=000", carry); end
        rstn = 1'b1;
        #2;
    endtask

    task automatic test_first_order();
        int e;
        order = 2'd0; din = 8'd128;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0);
            e = i % 2;
            n_cmp++;
            if (int'(dout) !== e) begin n_err++; $display("FAIL first_order[%0d] got=%0d exp=%0d", i, dout, e); end
            n_cmp++;
            if (dout_vld !== 1'b1) begin n_err++; $display("FAIL first_order_vld[%0d] got=%b exp=1", i, dout_vld); end
        end
    endtask

    task automatic test_zero_input();
        order = 2'd2; din = 8'd0;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0);
            n_cmp++;
            if (dout !== 4'sd0 || carry !== 3'b000) begin
                n_err++;
                $display("FAIL zero_input[%0d] got dout=%0d carry=%b exp dout=0 carry=000", i, dout, carry);
            end
        end
    endtask

    task automatic test_mean();
        int sum;
        sum = 0;
        order = 2'd2; din = 8'd100;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 4096; i++) begin
            cycle(1'b1, 1'b0);
            sum += int'(dout);
            n_cmp++;
            if (int'(dout) < -3 || int'(dout) > 4 || int'(dout) !== my) begin
                n_err++;
                $display("FAIL mean_sample[%0d] got=%0d exp=%0d (range -3..4)", i, dout, my);
            end
        end
        n_cmp++;
        if (sum < 1596 || sum > 1604) begin n_err++; $display("FAIL mean_sum got=%0d exp=1600+/-4", sum); end
    endtask

    task automatic test_en_gaps();
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        order = 2'd2; din = 8'd77;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            cycle(pat[i % 4], 1'b0);
            n_cmp++;
            if (dout_vld !== exp_vld) begin n_err++; $display("FAIL en_gap_vld[%0d] got=%b exp=%b", i, dout_vld, exp_vld); end
            n_cmp++;
            if (int'(dout) !== my || carry !== {mc[2], mc[1], mc[0]}) begin
                n_err++;
                $display("FAIL en_gap_dout[%0d] got=%0d/%b exp=%0d/%b", i, dout, carry, my, {mc[2], mc[1], mc[0]});
            end
        end
    endtask

    task automatic test_clr();
        order = 2'd2; din = 8'd200;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        n_cmp++;
        if (dout !== 4'sd0 || dout_vld !== 1'b0 || carry !== 3'b000) begin
            n_err++;
            $display("FAIL clr_priority got dout=%0d vld=%b carry=%b exp 0/0/000", dout, dout_vld, carry);
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0);
            n_cmp++;
            if (int'(dout) !== my || dout_vld !== 1'b1) begin
                n_err++;
                $display("FAIL clr_restart[%0d] got=%0d vld=%b exp=%0d vld=1", i, dout, dout_vld, my);
            end
        end
    endtask

    task automatic test_order_change();
        order = 2'd2; din = 8'd173;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0);
            n_cmp++;
            if (int'(dout) !== my) begin n_err++; $display("FAIL order2_run[%0d] got=%0d exp=%0d", i, dout, my); end
        end
        order = 2'd0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0);
            n_cmp++;
            if (carry[2:1] !== 2'b00 || int'(dout) !== my) begin
                n_err++;
                $display("FAIL order_drop[%0d] got dout=%0d carry=%b exp dout=%0d carry=0%b", i, dout, carry, my, mc[0]);
            end
        end
        order = 2'd2;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0);
            n_cmp++;
            if (int'(dout) !== my || carry !== {mc[2], mc[1], mc[0]}) begin
                n_err++;
                $display("FAIL order_regrow[%0d] got=%0d/%b exp=%0d/%b", i, dout, carry, my, {mc[2], mc[1], mc[0]});
            end
        end
    endtask

    task automatic test_order_clamp();
        order = 2'd3; din = 8'd45;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 1'b0);
            n_cmp++;
            if (int'(dout) !== my || carry !== {mc[2], mc[1], mc[0]}) begin
                n_err++;
                $display("FAIL order_clamp[%0d] got=%0d/%b exp=%0d/%b", i, dout, carry, my, {mc[2], mc[1], mc[0]});
            end
        end
    endtask

    task automatic test_rstn_mid_run();
        order = 2'd2; din = 8'd59;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (dout !== 4'sd0 || dout_vld !== 1'b0 || carry !== 3'b000) begin
            n_err++;
            $display("FAIL rstn_async got dout=%0d vld=%b carry=%b exp 0/0/000", dout, dout_vld, carry);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_clr();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0);
            n_cmp++;
            if (int'(dout) !== my || dout_vld !== 1'b1) begin
                n_err++;
                $display("FAIL rstn_resume[%0d] got=%0d vld=%b exp=%0d vld=1", i, dout, dout_vld, my);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_first_order();
        test_zero_input();
        test_mean();
        test_en_gaps();
        test_clr();
        test_order_change();
        test_order_clamp();
        test_rstn_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
